truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential stimulus/response harness for the small combinational example netlists (6 inputs, 1 output). It sits directly upstream and downstream of such a netlist. It drives every input vector in ascending order and samples the netlist output after a settle delay. It accumulates the full truth table plus its ones-count and hands the result downstream over a valid/ready handshake. Results feed the visualisation flow and equivalence checks.

## Interface
- N_IN, default 6: number of netlist inputs; table has 2**N_IN entries.
- SETTLE, default 1: cycles a vector is held before sampling; legal range 1..15.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel a sweep in progress.
- vec_out  output  N_IN  stimulus; for the 6-input netlists ordered {a,b,c,d,e,g}, a = MSB.
- f_in  input  1  netlist output, combinational from vec_out.
- busy  output  1  high in SETTLE and SAMPLE.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- table_out  output  2**N_IN  bit i = f_in sampled while vec_out == i.
- ones_count  output  N_IN+1  number of 1 bits in table_out.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE. State encoding is internal.
- IDLE, start=1: next state SETTLE. Also vec_out←0, settle counter←0, table_out←0, ones_count←0.
- SETTLE: counter increments each cycle. After SETTLE cycles in this state, go to SAMPLE; vec_out is held throughout.
- SAMPLE: table_out[vec_out]←f_in; ones_count += f_in.
  - If vec_out == 2**N_IN−1: go to DONE.
  - Otherwise: vec_out+1, counter←0, go to SETTLE.
- DONE: out_valid=1. table_out and ones_count are stable. out_valid&out_ready → IDLE next cycle.
- table_out and ones_count are retained in IDLE until the next start. vec_out returns to 0 in IDLE.
- abort in SETTLE or SAMPLE: IDLE next cycle, no sample taken that cycle, table_out/ones_count cleared, out_valid never asserted. abort in IDLE or DONE is ignored.
- start outside IDLE is ignored. It is not queued.
- start and abort both high in IDLE: start wins.
- vec_out counter must not wrap. The final index ends the sweep.
- ones_count width N_IN+1, so the all-ones table (64 for N_IN=6) is representable.

## Timing
- Reset values: vec_out=0, busy=0, out_valid=0, table_out=0, ones_count=0, state IDLE.
- Reset asserted mid-sweep: all outputs take their reset values immediately (asynchronous). No partial result is presented.
- All outputs are registered.
- start sampled at cycle 0. Vector k is on vec_out from cycle 1+k·(SETTLE+1) and is sampled at cycle 1+k·(SETTLE+1)+SETTLE.
- out_valid rises at cycle 1+2**N_IN·(SETTLE+1), i.e. cycle 129 for the defaults.
- busy falls in the same cycle that out_valid rises.
- out_valid holds indefinitely while out_ready=0.
- Handshake completes on a cycle with out_valid&out_ready. out_valid is low the following cycle.
- Back-to-back sweeps: earliest next start is the cycle after handshake completion.

## Structure
- Shared package sweeper_pkg: state enum type, SETTLE bounds constants, and a function returning the table width from N_IN.
- No sub-module. FSM, settle counter, vector counter and accumulators live in one module.
- The netlist under test is instantiated by the bench or top level, not inside this block.

## Test plan
- Reset, then start with f_in tied 0 → out_valid at cycle 129; table_out=0, ones_count=0.
- Reference 6-input netlist f = ~g·a·b·c | ~g·c·d·~e | a·b·c·d·~e, SETTLE=1 → table_out=0x7500100010001000, ones_count=8. Bits set: 12, 28, 44, 56, 58, 60, 61, 62.
- f_in tied 1, SETTLE=3 → out_valid at cycle 257; table_out all ones; ones_count=64.
- out_ready held 0 for 20 cycles after out_valid → outputs stable for all 20 cycles. A start pulse in that window is ignored. Raising out_ready gives IDLE next cycle.
- abort at cycle 40 of a sweep → state IDLE at cycle 41, vec_out=0, table_out=0, out_valid never rises. A subsequent start runs a full sweep.
- rst_n pulsed low at cycle 70 → outputs at reset values asynchronously. After release, start gives the same result as a clean run.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared definitions for the truth-table sweep harness: FSM states,
// settle-delay bounds and table sizing.
package sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } sweep_state_t;

  localparam int SETTLE_MIN   = 1;
  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = 4;

  function automatic int table_w(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a small combinational netlist in ascending
// order, samples its output after a settle delay and presents the truth table.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN   = 6,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic [N_IN-1:0]           vec_out,
  input  logic                      f_in,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [table_w(N_IN)-1:0]  table_out,
  output logic [N_IN:0]             ones_count
);

  localparam logic [N_IN-1:0]         LAST_VEC    = {N_IN{1'b1}};
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);

  sweep_state_t              state;
  logic [SETTLE_CNT_W-1:0]   settle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec_out    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      table_out  <= '0;
      ones_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          vec_out <= '0;
          if (start) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            table_out  <= '0;
            ones_count <= '0;
            busy       <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            state      <= ST_IDLE;
            vec_out    <= '0;
            busy       <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
              state <= ST_SAMPLE;
            end
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            state      <= ST_IDLE;
            vec_out    <= '0;
            busy       <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
          end else begin
            table_out[vec_out] <= f_in;
            ones_count         <= ones_count + {{N_IN{1'b0}}, f_in};
            // The final index ends the sweep; the vector counter never wraps.
            if (vec_out == LAST_VEC) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              vec_out    <= vec_out + 1'b1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            vec_out   <= '0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised scoreboard bench for truth_table_sweeper: a driver queues the
// expected table per sweep, a monitor checks each presented result.
module tb_truth_table_sweeper;
  import sweeper_pkg::*;

  localparam int N_IN = 6;
  localparam int TW   = 64;
  localparam int S1   = 1;
  localparam int S3   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start, abort, out_ready, f_in;
  logic [N_IN-1:0] vec_out;
  logic            busy, out_valid;
  logic [TW-1:0]   table_out;
  logic [N_IN:0]   ones_count;

  logic            start3;
  logic [N_IN-1:0] vec_out3;
  logic            busy3, out_valid3;
  logic [TW-1:0]   table_out3;
  logic [N_IN:0]   ones_count3;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(S1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_out(vec_out), .f_in(f_in), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .table_out(table_out), .ones_count(ones_count)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(S3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0),
    .vec_out(vec_out3), .f_in(1'b1), .busy(busy3), .out_valid(out_valid3),
    .out_ready(1'b1), .table_out(table_out3), .ones_count(ones_count3)
  );

  // Netlist stand-in: constant, the reference netlist, or a random table.
  int            f_mode;
  logic [TW-1:0] rand_tt;

  function automatic logic model_f(input int mode, input logic [TW-1:0] tt, input int idx);
    logic a, b, c, d, e, g;
    a = idx[5]; b = idx[4]; c = idx[3]; d = idx[2]; e = idx[1]; g = idx[0];
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (~g & a & b & c) | (~g & c & d & ~e) | (a & b & c & d & ~e);
      default: return tt[idx];
    endcase
  endfunction

  always_comb f_in = model_f(f_mode, rand_tt, int'(vec_out));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  typedef struct {
    logic [TW-1:0] tbl;
    int            ones;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  // Called at a negedge; start is sampled by the following posedge (cycle 0).
  task automatic issue_start(input bit push, output int base,
                             output logic [TW-1:0] tbl, output int ones);
    exp_t e;
    tbl  = '0;
    ones = 0;
    for (int i = 0; i < TW; i++) begin
      tbl[i] = model_f(f_mode, rand_tt, i);
      ones  += int'(tbl[i]);
    end
    base  = cyc;
    e.tbl  = tbl;
    e.ones = ones;
    e.cyc  = base + 1 + TW * (S1 + 1);
    if (push) sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!out_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("timeout_out_valid");
  endtask

  // Monitor: pops the scoreboard when a result is first presented.
  logic          prev_valid = 1'b0;
  logic          prev_busy = 1'b0;
  logic [TW-1:0] held_tbl;
  logic [N_IN:0] held_ones;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          mon_e = sb.pop_front();
          check("result_table", table_out, mon_e.tbl);
          check("result_ones", TW'(ones_count), TW'(mon_e.ones));
          check("valid_cycle", TW'(cyc), TW'(mon_e.cyc));
          check("busy_falls_with_valid", TW'({prev_busy, busy}), TW'(2'b10));
        end
        held_tbl  = table_out;
        held_ones = ones_count;
      end else if (out_valid && prev_valid) begin
        check("hold_table", table_out, held_tbl);
        check("hold_ones", TW'(ones_count), TW'(held_ones));
      end
    end
    prev_valid = out_valid;
    prev_busy  = busy;
  end

  int            base, base3, ones_e;
  logic [TW-1:0] tbl_e;

  initial begin
    start = 1'b0; abort = 1'b0; out_ready = 1'b1; start3 = 1'b0;
    f_mode = 0; rand_tt = '0;
    repeat (3) @(negedge clk);
    check("rst_vec_out", TW'(vec_out), '0);
    check("rst_busy", TW'(busy), '0);
    check("rst_out_valid", TW'(out_valid), '0);
    check("rst_table", table_out, '0);
    check("rst_ones", TW'(ones_count), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // f tied 0: result at cycle 129, empty table.
    f_mode = 0;
    issue_start(1'b1, base, tbl_e, ones_e);
    check("busy_during_sweep", TW'(busy), TW'(1'b1));
    wait_valid(300);
    @(negedge clk);
    check("handshake_valid_low", TW'(out_valid), '0);
    check("idle_vec_zero", TW'(vec_out), '0);
    check("idle_table_retained", table_out, tbl_e);

    // Reference netlist, back-to-back with the previous handshake.
    f_mode = 2;
    issue_start(1'b1, base, tbl_e, ones_e);
    wait_valid(300);
    check("ref_table_const", table_out, 64'h7500100010001000);
    check("ref_ones_const", TW'(ones_count), TW'(8));
    @(negedge clk);

    // Random tables.
    for (int r = 0; r < 3; r++) begin
      f_mode  = 3;
      rand_tt = {$urandom, $urandom};
      issue_start(1'b1, base, tbl_e, ones_e);
      wait_valid(300);
      @(negedge clk);
      check("rand_table_retained", table_out, tbl_e);
    end

    // SETTLE=3 instance with f tied 1.
    base3  = cyc;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int n = 0; n < 400 && !out_valid3; n++) @(negedge clk);
    if (!out_valid3) fail_now("timeout_out_valid3");
    check("s3_valid_cycle", TW'(cyc), TW'(base3 + 1 + TW * (S3 + 1)));
    check("s3_table_ones", table_out3, {TW{1'b1}});
    check("s3_ones_count", TW'(ones_count3), TW'(64));
    check("s3_busy_low", TW'(busy3), '0);
    @(negedge clk);

    // Backpressure: result held 20 cycles, start in the window ignored.
    f_mode    = 3;
    rand_tt   = {$urandom, $urandom};
    out_ready = 1'b0;
    issue_start(1'b1, base, tbl_e, ones_e);
    wait_valid(300);
    for (int n = 0; n < 20; n++) begin
      start = (n == 5);
      @(negedge clk);
    end
    start = 1'b0;
    check("held_valid_after_20", TW'(out_valid), TW'(1'b1));
    check("held_busy_low", TW'(busy), '0);
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid_low", TW'(out_valid), '0);
    repeat (3) @(negedge clk);
    check("ignored_start_not_queued", TW'(busy), '0);

    // Abort during cycle 40 (a SAMPLE cycle for vector 19).
    f_mode = 1;
    issue_start(1'b0, base, tbl_e, ones_e);
    while (cyc < base + 40) @(negedge clk);
    check("pre_abort_vec", TW'(vec_out), TW'(19));
    check("pre_abort_ones", TW'(ones_count), TW'(19));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", TW'(busy), '0);
    check("abort_vec", TW'(vec_out), '0);
    check("abort_table", table_out, '0);
    check("abort_ones", TW'(ones_count), '0);
    check("abort_valid", TW'(out_valid), '0);
    repeat (150) @(negedge clk);
    f_mode = 2;
    issue_start(1'b1, base, tbl_e, ones_e);
    wait_valid(300);
    @(negedge clk);

    // Asynchronous reset mid-sweep, then a clean rerun of the same table.
    f_mode  = 3;
    rand_tt = {$urandom, $urandom};
    issue_start(1'b0, base, tbl_e, ones_e);
    while (cyc < base + 70) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vec", TW'(vec_out), '0);
    check("arst_busy", TW'(busy), '0);
    check("arst_valid", TW'(out_valid), '0);
    check("arst_table", table_out, '0);
    check("arst_ones", TW'(ones_count), '0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue_start(1'b1, base, tbl_e, ones_e);
    wait_valid(300);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", TW'(sb.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
